// File: rtl/t1_quiesce_monitor.sv
// t1_quiesce_monitor
// Watches DUT AXI read/write traffic and retire activity and raises `idle`
// once nothing is outstanding and the bus has been quiet for QUIET_CYCLES
// consecutive cycles. It also latches sticky accounting errors when a
// counter would underflow or overflow.
//
// Handshake semantics: each *_fire input is the already-qualified
// valid&ready of its channel, sampled once per rising clock edge. A fire
// means exactly one transfer happened in that cycle. There is no
// backpressure from this block.
module t1_quiesce_monitor #(
  parameter int MAX_OUTSTANDING = 64,
  parameter int QUIET_CYCLES    = 16,
  parameter int CNT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             initFlag,
  input  logic             ar_fire,
  input  logic             r_last_fire,
  input  logic             aw_fire,
  input  logic             b_fire,
  input  logic             retire_valid,
  output logic             idle,
  output logic [CNT_W-1:0] rd_outstanding,
  output logic [CNT_W-1:0] wr_outstanding,
  output logic             err_underflow,
  output logic             err_overflow
);

  localparam int QW = $clog2(QUIET_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTSTANDING);
  localparam logic [QW-1:0]    Q_MAX   = QW'(QUIET_CYCLES);

  typedef enum logic [1:0] {
    BUSY  = 2'd0,
    QUIET = 2'd1,
    IDLE  = 2'd2
  } state_t;

  // Kept as a named enum signal so checkers can bind to it hierarchically.
  state_t state;
  state_t state_next;

  logic [CNT_W-1:0] rd_next;
  logic [CNT_W-1:0] wr_next;
  logic             rd_unf;
  logic             rd_ovf;
  logic             wr_unf;
  logic             wr_ovf;
  logic             activity;
  logic             quiet;
  logic [QW-1:0]    quiet_cnt;
  logic [QW-1:0]    quiet_cnt_next;

  // Read counter next value; a simultaneous issue and completion cancel out.
  always_comb begin
    rd_next = rd_outstanding;
    rd_unf  = 1'b0;
    rd_ovf  = 1'b0;
    if (ar_fire && !r_last_fire) begin
      if (rd_outstanding == CNT_MAX) rd_ovf = 1'b1;
      else                           rd_next = rd_outstanding + 1'b1;
    end else if (r_last_fire && !ar_fire) begin
      if (rd_outstanding == '0) rd_unf = 1'b1;
      else                      rd_next = rd_outstanding - 1'b1;
    end
  end

  // Write counter next value; same rules as the read side.
  always_comb begin
    wr_next = wr_outstanding;
    wr_unf  = 1'b0;
    wr_ovf  = 1'b0;
    if (aw_fire && !b_fire) begin
      if (wr_outstanding == CNT_MAX) wr_ovf = 1'b1;
      else                           wr_next = wr_outstanding + 1'b1;
    end else if (b_fire && !aw_fire) begin
      if (wr_outstanding == '0) wr_unf = 1'b1;
      else                      wr_next = wr_outstanding - 1'b1;
    end
  end

  // Quiet detection, saturating window count and next FSM state.
  always_comb begin
    activity = ar_fire | r_last_fire | aw_fire | b_fire | retire_valid | initFlag;
    quiet    = (rd_outstanding == '0) && (wr_outstanding == '0) && !activity;

    quiet_cnt_next = '0;
    if (quiet) begin
      if (quiet_cnt == Q_MAX) quiet_cnt_next = quiet_cnt;
      else                    quiet_cnt_next = quiet_cnt + 1'b1;
    end

    state_next = BUSY;
    if (quiet) begin
      if (quiet_cnt_next == Q_MAX) state_next = IDLE;
      else if (state == IDLE)      state_next = IDLE;
      else                         state_next = QUIET;
    end
  end

  // All state and outputs are flops; errors are sticky until reset.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rd_outstanding <= '0;
      wr_outstanding <= '0;
      err_underflow  <= 1'b0;
      err_overflow   <= 1'b0;
      quiet_cnt      <= '0;
      state          <= BUSY;
      idle           <= 1'b0;
    end else begin
      rd_outstanding <= rd_next;
      wr_outstanding <= wr_next;
      if (rd_unf || wr_unf) err_underflow <= 1'b1;
      if (rd_ovf || wr_ovf) err_overflow  <= 1'b1;
      quiet_cnt      <= quiet_cnt_next;
      state          <= state_next;
      idle           <= (state_next == IDLE);
    end
  end

endmodule

// File: tb/tb_t1_quiesce_monitor.sv
// Directed bench for t1_quiesce_monitor: a vector table for the single-cycle
// and window-timing behaviour, plus hand sequences for saturation and
// asynchronous reset.
module tb_t1_quiesce_monitor;

  localparam int MAXO  = 64;
  localparam int QC    = 16;
  localparam int CNT_W = $clog2(MAXO + 1);
  localparam int OW    = 2 * CNT_W + 3;

  logic             clock;
  logic             reset;
  logic             initFlag;
  logic             ar_fire;
  logic             r_last_fire;
  logic             aw_fire;
  logic             b_fire;
  logic             retire_valid;
  logic             idle;
  logic [CNT_W-1:0] rd_outstanding;
  logic [CNT_W-1:0] wr_outstanding;
  logic             err_underflow;
  logic             err_overflow;

  t1_quiesce_monitor #(
    .MAX_OUTSTANDING(MAXO),
    .QUIET_CYCLES   (QC)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .initFlag      (initFlag),
    .ar_fire       (ar_fire),
    .r_last_fire   (r_last_fire),
    .aw_fire       (aw_fire),
    .b_fire        (b_fire),
    .retire_valid  (retire_valid),
    .idle          (idle),
    .rd_outstanding(rd_outstanding),
    .wr_outstanding(wr_outstanding),
    .err_underflow (err_underflow),
    .err_overflow  (err_overflow)
  );

  // Clock and reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic             ar;
    logic             rl;
    logic             aw;
    logic             b;
    logic             ret;
    logic             init;
    logic [CNT_W-1:0] erd;
    logic [CNT_W-1:0] ewr;
    logic             eidle;
    logic             eunf;
    logic             eovf;
  } vec_t;

  vec_t           vecs[128];
  int             nv;
  int             checks;
  int             errors;
  logic [OW-1:0]  exp_q[$];

  function automatic logic [OW-1:0] pack(input logic [CNT_W-1:0] rd, input logic [CNT_W-1:0] wr,
                                         input logic id, input logic unf, input logic ovf);
    return {rd, wr, id, unf, ovf};
  endfunction

  function automatic logic [OW-1:0] actual();
    return {rd_outstanding, wr_outstanding, idle, err_underflow, err_overflow};
  endfunction

  task automatic add(input logic ar, input logic rl, input logic aw, input logic b,
                     input logic ret, input logic init, input int erd, input int ewr,
                     input logic eidle, input logic eunf, input logic eovf);
    vecs[nv].ar    = ar;
    vecs[nv].rl    = rl;
    vecs[nv].aw    = aw;
    vecs[nv].b     = b;
    vecs[nv].ret   = ret;
    vecs[nv].init  = init;
    vecs[nv].erd   = CNT_W'(erd);
    vecs[nv].ewr   = CNT_W'(ewr);
    vecs[nv].eidle = eidle;
    vecs[nv].eunf  = eunf;
    vecs[nv].eovf  = eovf;
    nv++;
  endtask

  // Quiet steps: idle stays low for QC-1 steps and rises on the QC-th.
  task automatic add_window(input logic eunf, input logic eovf);
    for (int i = 1; i <= QC; i++) add(0, 0, 0, 0, 0, 0, 0, 0, (i == QC), eunf, eovf);
  endtask

  // Driver tasks
  task automatic drive(input logic ar, input logic rl, input logic aw, input logic b,
                       input logic ret, input logic init);
    ar_fire      = ar;
    r_last_fire  = rl;
    aw_fire      = aw;
    b_fire       = b;
    retire_valid = ret;
    initFlag     = init;
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    drive(0, 0, 0, 0, 0, 0);
    reset = 1'b0;
    step();
    step();
    reset = 1'b1;
  endtask

  // Scoreboard compare
  task automatic check(input string name, input logic [OW-1:0] act, input logic [OW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got rd=%0d wr=%0d idle=%0b unf=%0b ovf=%0b want rd=%0d wr=%0d idle=%0b unf=%0b ovf=%0b",
               name, act[OW-1 -: CNT_W], act[2+CNT_W -: CNT_W], act[2], act[1], act[0],
               exp[OW-1 -: CNT_W], exp[2+CNT_W -: CNT_W], exp[2], exp[1], exp[0]);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    nv     = 0;

    // Power-on after reset release; initFlag holds one cycle, then quiet window.
    add(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    add_window(0, 0);
    // Three read issues, five busy cycles, three completions, then window.
    add(1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    add(1, 0, 0, 0, 0, 0, 2, 0, 0, 0, 0);
    add(1, 0, 0, 0, 0, 0, 3, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) add(0, 0, 0, 0, 0, 0, 3, 0, 0, 0, 0);
    add(0, 1, 0, 0, 0, 0, 2, 0, 0, 0, 0);
    add(0, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    add(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    add_window(0, 0);
    // Simultaneous issue and completion at zero: no change, no error.
    add(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    // Write completion with nothing outstanding: sticky underflow.
    add(0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 0);
    add_window(1, 0);
    // Single retire pulse knocks idle down for a full window.
    add(0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0);
    add_window(1, 0);

    do_reset();
    check("reset_state", actual(), pack(0, 0, 0, 0, 0));

    for (int i = 0; i < nv; i++) begin
      drive(vecs[i].ar, vecs[i].rl, vecs[i].aw, vecs[i].b, vecs[i].ret, vecs[i].init);
      exp_q.push_back(pack(vecs[i].erd, vecs[i].ewr, vecs[i].eidle, vecs[i].eunf, vecs[i].eovf));
      step();
      check($sformatf("vec%0d", i), actual(), exp_q.pop_front());
    end
    drive(0, 0, 0, 0, 0, 0);

    // Fill the read counter to MAX, then fire issue+completion together.
    do_reset();
    for (int i = 0; i < MAXO; i++) begin
      drive(1, 0, 0, 0, 0, 0);
      step();
    end
    check("rd_at_max", actual(), pack(MAXO, 0, 0, 0, 0));
    drive(1, 1, 0, 0, 0, 0);
    step();
    check("rd_both_at_max", actual(), pack(MAXO, 0, 0, 0, 0));

    // 65 write issues: saturate at MAX and flag overflow on the 65th.
    for (int i = 0; i < MAXO; i++) begin
      drive(0, 0, 1, 0, 0, 0);
      step();
    end
    check("wr_at_max", actual(), pack(MAXO, MAXO, 0, 0, 0));
    drive(0, 0, 1, 0, 0, 0);
    step();
    check("wr_overflow", actual(), pack(MAXO, MAXO, 0, 0, 1));
    drive(0, 0, 0, 0, 0, 0);
    step();
    check("ovf_sticky", actual(), pack(MAXO, MAXO, 0, 0, 1));

    // Asynchronous reset mid-cycle with five reads outstanding.
    do_reset();
    for (int i = 0; i < 5; i++) begin
      drive(1, 0, 0, 0, 0, 0);
      step();
    end
    drive(0, 0, 0, 0, 0, 0);
    check("rd_five", actual(), pack(5, 0, 0, 0, 0));
    #3;
    reset = 1'b0;
    #1;
    check("async_reset", actual(), pack(0, 0, 0, 0, 0));
    step();
    reset = 1'b1;

    // After release with no activity, idle rises after exactly QC cycles.
    for (int i = 1; i < QC; i++) step();
    check("post_reset_not_yet", actual(), pack(0, 0, 0, 0, 0));
    step();
    check("post_reset_idle", actual(), pack(0, 0, 1, 0, 0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
